// File: rtl/sprite_arb_pkg.sv
// sprite_arb_pkg: shared widths, tag struct and pointer-wrap helper for sprite_rom_arbiter (no ports)
package sprite_arb_pkg;
  localparam int SPRITE_ADDR_W = 16;
  localparam int SPRITE_DATA_W = 8;
  localparam int SPRITE_MAX_REQ = 8;
  localparam int IDX_W = $clog2(SPRITE_MAX_REQ);
  typedef logic [IDX_W-1:0] idx_t;
  typedef struct packed {
    logic valid;
    idx_t idx;
  } tag_t;
  function automatic idx_t wrap_inc(idx_t k, int n);
    return (int'(k) == n - 1) ? '0 : k + 1'b1;
  endfunction
endpackage

// File: rtl/sprite_rom_arbiter_if.sv
// sprite_rom_arbiter_if: client bus (req, req_addr, gnt, rvalid, rdata), ROM port (rom_rd, rom_addr, rom_q) and busy; slave = arbiter, master = clients/ROM
interface sprite_rom_arbiter_if
  import sprite_arb_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int ADDR_W = SPRITE_ADDR_W,
  parameter int DATA_W = SPRITE_DATA_W
);
  logic [N_REQ-1:0] req;
  logic [N_REQ*ADDR_W-1:0] req_addr;
  logic [N_REQ-1:0] gnt;
  logic [N_REQ-1:0] rvalid;
  logic [DATA_W-1:0] rdata;
  logic rom_rd;
  logic [ADDR_W-1:0] rom_addr;
  logic [DATA_W-1:0] rom_q;
  logic busy;
  modport slave (
    input req, req_addr, rom_q,
    output gnt, rvalid, rdata, rom_rd, rom_addr, busy
  );
  modport master (
    output req, req_addr, rom_q,
    input gnt, rvalid, rdata, rom_rd, rom_addr, busy
  );
endinterface

// File: rtl/sprite_rom_arbiter_rr_picker.sv
// rr_picker: combinational round-robin pick from ptr upward (ports: req, ptr in; one-hot gnt, encoded idx, any out)
module rr_picker
  import sprite_arb_pkg::*;
#(
  parameter int N_REQ = 4
) (
  input  logic [N_REQ-1:0] req,
  input  idx_t             ptr,
  output logic [N_REQ-1:0] gnt,
  output idx_t             idx,
  output logic             any
);
  always_comb begin
    int j;
    j = 0;
    gnt = '0;
    idx = '0;
    any = 1'b0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      j = int'(ptr) + i;
      j = (j >= N_REQ) ? j - N_REQ : j;
      if (req[j]) begin
        gnt = N_REQ'(1) << j;
        idx = idx_t'(j);
        any = 1'b1;
      end
    end
  end
endmodule

// File: rtl/sprite_rom_arbiter.sv
// sprite_rom_arbiter: round-robin sharing of one sprite ROM read port (ports: Clk, Reset, bus slave: req/req_addr/gnt/rvalid/rdata/rom_rd/rom_addr/rom_q/busy); define SPRITE_ROM_ARB_PRIO0_EN to give client 0 absolute priority
module sprite_rom_arbiter
  import sprite_arb_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int ADDR_W = SPRITE_ADDR_W,
  parameter int DATA_W = SPRITE_DATA_W,
  parameter int ROM_LAT = 2
) (
  input logic Clk,
  input logic Reset,
  sprite_rom_arbiter_if.slave bus
);
`ifdef SPRITE_ROM_ARB_PRIO0_EN
  localparam bit PRIO0 = 1'b1;
`else
  localparam bit PRIO0 = 1'b0;
`endif
  logic [N_REQ-1:0] pick_gnt;
  idx_t pick_idx, ptr, k;
  logic pick_any, prio, fire, hit;
  tag_t tags [ROM_LAT];
  logic [DATA_W-1:0] rdata_q;
  rr_picker #(.N_REQ(N_REQ)) u_pick (
    .req(bus.req),
    .ptr(ptr),
    .gnt(pick_gnt),
    .idx(pick_idx),
    .any(pick_any)
  );
  always_comb begin
    prio = PRIO0 && bus.req[0];
    fire = !Reset && (prio || pick_any);
    k = prio ? '0 : pick_idx;
    bus.gnt = fire ? (prio ? N_REQ'(1) : pick_gnt) : '0;
    bus.rom_rd = fire;
    bus.rom_addr = fire ? bus.req_addr[k*ADDR_W +: ADDR_W] : '0;
    hit = !Reset && tags[ROM_LAT-1].valid;
    bus.rvalid = hit ? N_REQ'(1) << tags[ROM_LAT-1].idx : '0;
    bus.rdata = hit ? bus.rom_q : rdata_q;
    bus.busy = 1'b0;
    for (int i = 0; i < ROM_LAT; i++) bus.busy = bus.busy | tags[i].valid;
    bus.busy = bus.busy && !Reset;
  end
  always_ff @(posedge Clk) begin
    if (Reset) begin
      for (int i = 0; i < ROM_LAT; i++) tags[i] <= '0;
      ptr <= '0;
      rdata_q <= '0;
    end else begin
      tags[0] <= '{valid: fire, idx: k};
      for (int i = 1; i < ROM_LAT; i++) tags[i] <= tags[i-1];
      if (fire && !prio) ptr <= wrap_inc(k, N_REQ);
      if (hit) rdata_q <= bus.rom_q;
    end
  end
endmodule

// File: tb/tb_sprite_rom_arbiter.sv
// tb_sprite_rom_arbiter: directed stimulus with a return-path scoreboard for sprite_rom_arbiter
module tb_sprite_rom_arbiter;
`ifdef SPRITE_ROM_ARB_PRIO0_EN
  localparam bit P = 1'b1;
`else
  localparam bit P = 1'b0;
`endif
  localparam logic [63:0] AV = 64'h0D33_0123_0B11_0A00;
  logic Clk = 1'b0;
  logic Reset = 1'b1;
  always #5 Clk = ~Clk;
  sprite_rom_arbiter_if #(.N_REQ(4), .ADDR_W(16), .DATA_W(8)) bus ();
  sprite_rom_arbiter #(.N_REQ(4), .ADDR_W(16), .DATA_W(8), .ROM_LAT(2)) dut (
    .Clk(Clk),
    .Reset(Reset),
    .bus(bus)
  );
  function automatic logic [7:0] romf(logic [15:0] a);
    return a[7:0] ^ a[15:8] ^ 8'h5A;
  endfunction
  logic [15:0] s1, s2;
  always @(posedge Clk) begin
    s1 <= bus.rom_addr;
    s2 <= s1;
  end
  assign bus.rom_q = romf(s2);
  logic [15:0] addr [4];
  assign bus.req_addr = {addr[3], addr[2], addr[1], addr[0]};
  int cyc = 0;
  always @(posedge Clk) cyc <= cyc + 1;
  typedef struct {
    int idx;
    logic [7:0] d;
    int due;
  } exp_t;
  exp_t q[$];
  int n_chk = 0;
  int n_fail = 0;
  logic [7:0] last_d = 8'h00;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
    end
  endtask
  always @(negedge Clk) begin
    if (bus.rvalid != 0) begin
      if (q.size() == 0) chk("rvalid unexpected", 32'(bus.rvalid), 0);
      else begin
        exp_t e;
        e = q.pop_front();
        chk("rvalid", 32'(bus.rvalid), 32'(1) << e.idx);
        chk("rdata", 32'(bus.rdata), 32'(e.d));
        chk("latency", cyc, e.due);
        last_d = e.d;
      end
    end else begin
      if (q.size() != 0 && q[0].due <= cyc) begin
        chk("rvalid missing", 0, 32'(1) << q[0].idx);
        void'(q.pop_front());
      end
      if (Reset) last_d = 8'h00;
      else chk("rdata hold", 32'(bus.rdata), 32'(last_d));
    end
  end
  task automatic step(input logic r, input logic [3:0] rq, input logic [3:0] eg, input int eb, input logic [63:0] av);
    int k;
    k = 0;
    @(posedge Clk);
    #1;
    Reset = r;
    bus.req = rq;
    for (int i = 0; i < 4; i++) addr[i] = av[i*16 +: 16];
    @(negedge Clk);
    chk("gnt", 32'(bus.gnt), 32'(eg));
    chk("rom_rd", 32'(bus.rom_rd), 32'(|eg));
    if (eg != 0) begin
      for (int i = 0; i < 4; i++) if (eg[i]) k = i;
      chk("rom_addr", 32'(bus.rom_addr), 32'(addr[k]));
      if (!r) q.push_back('{k, romf(addr[k]), cyc + 2});
    end
    if (eb >= 0) chk("busy", 32'(bus.busy), eb);
  endtask
  initial begin
    bus.req = '0;
    for (int i = 0; i < 4; i++) addr[i] = '0;
    step(1, 4'hF, 4'h0, 0, AV);
    step(1, 4'hF, 4'h0, 0, AV);
    chk("reset rdata", 32'(bus.rdata), 0);
    chk("reset rom_addr", 32'(bus.rom_addr), 0);
    chk("reset rvalid", 32'(bus.rvalid), 0);
    step(0, 4'b0100, 4'b0100, 0, AV);
    step(0, 4'b0000, 4'b0000, 1, AV);
    step(0, 4'b0000, 4'b0000, 1, AV);
    step(0, 4'b0000, 4'b0000, 0, AV);
    step(0, 4'b0010, 4'b0010, 0, AV);
    void'(q.pop_back());
    step(1, 4'b0000, 4'b0000, 0, AV);
    step(0, 4'b0000, 4'b0000, 0, AV);
    step(0, 4'b0000, 4'b0000, 0, AV);
    for (int i = 0; i < 8; i++) step(0, 4'hF, P ? 4'b0001 : 4'b0001 << (i % 4), i == 0 ? 0 : 1, AV);
    step(0, 4'b0010, 4'b0010, 1, AV);
    step(0, 4'b1001, P ? 4'b0001 : 4'b1000, 1, AV);
    step(0, 4'b1001, 4'b0001, 1, AV);
    for (int i = 0; i < 3; i++) step(0, 4'b1000, 4'b1000, 1, {16'h0010 + 16'(i), AV[47:0]});
    step(0, 4'b0000, 4'b0000, 1, AV);
    step(0, 4'b0000, 4'b0000, 1, AV);
    step(0, 4'b0000, 4'b0000, 0, AV);
    for (int i = 0; i < 4; i++) step(0, 4'hF, P ? 4'b0001 : 4'b0001 << i, -1, AV);
    for (int i = 0; i < 3; i++) step(0, 4'hE, 4'b0010 << i, 1, AV);
    step(0, 4'b0000, 4'b0000, 1, AV);
    step(0, 4'b0000, 4'b0000, 1, AV);
    step(0, 4'b0000, 4'b0000, 0, AV);
    chk("queue drained", q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/sprite_rom_arbiter.md
Name: sprite_rom_arbiter

Overview:
- Shares one synchronous sprite/tile ROM read port among up to N_REQ render clients: background, fireboy, icegirl, score/gem.
- Round-robin grant, one read issued per Clk cycle, fixed-latency return routed back to the issuing client.
- Sits between the per-object sprite renderers and a single M9K ROM, so each renderer no longer needs its own ROM copy.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- ADDR_W, 16, ROM address width.
- DATA_W, 8, ROM word width (palette index).
- ROM_LAT, 2, ROM read latency in cycles, from rom_rd/rom_addr to rom_q valid (1..4).

Ports:
- Clk  in  1  system clock.
- Reset  in  1  synchronous, active-high reset.
- req  in  N_REQ  per-client read request level.
- req_addr  in  N_REQ*ADDR_W  packed addresses; client i uses bits [i*ADDR_W +: ADDR_W].
- gnt  out  N_REQ  one-hot, one-cycle pulse: client i's request accepted this cycle.
- rvalid  out  N_REQ  one-hot, one-cycle pulse: rdata belongs to client i.
- rdata  out  DATA_W  returned ROM word, shared by all clients.
- rom_rd  out  1  ROM read strobe.
- rom_addr  out  ADDR_W  ROM address.
- rom_q  in  DATA_W  ROM output.
- busy  out  1  high while any read is in flight.

Behaviour:
- Reset: gnt=0, rvalid=0, rdata=0, rom_rd=0, rom_addr=0, busy=0, rr pointer=0, in-flight pipeline cleared.
- Reset asserted mid-operation: every in-flight read is dropped and no rvalid is produced for it, even after Reset deasserts.
- Handshake:
  - Client raises req with a stable req_addr and holds both until it sees gnt.
  - gnt is combinational from the current req and rr pointer.
  - rom_rd and rom_addr are driven in the same cycle as gnt.
  - Client may drop or change req the cycle after gnt. Back-to-back requests from one client are legal and can be granted every cycle if uncontested.
- Arbitration:
  - Search starts at index ptr, then ptr+1 … wrapping modulo N_REQ. The first asserted req wins.
  - On a grant to index k, ptr <= (k+1) mod N_REQ. With no grant, ptr holds.
  - At most one gnt bit is high per cycle.
- Return path:
  - Tag shift register of depth ROM_LAT; each stage holds {valid, client index}.
  - Stage 0 is loaded with {rom_rd, k}.
  - When the last stage is valid, rvalid[idx] pulses and rdata <= rom_q for that cycle, registered to match ROM_LAT timing.
  - Latency from gnt to rvalid is exactly ROM_LAT cycles.
  - rdata holds its last value when no rvalid is high.
- busy = OR of the valid bits across all tag stages.
- Throughput: 1 read/cycle. Under full contention each of N_REQ clients gets one grant every N_REQ cycles, so wait is at most N_REQ-1 cycles.
- A request arriving in the same cycle as a return to the same client is legal; grant and return are independent.
- A req bit for an index ≥ N_REQ does not exist; unused packed address bits are ignored.

Optional Feature:
- Macro: SPRITE_ROM_ARB_PRIO0_EN.
- Defined: client 0 (background, pixel-rate) has absolute priority.
  - If req[0]=1, client 0 is granted regardless of ptr, and ptr is not updated.
  - Clients 1..N_REQ-1 round-robin among themselves only in cycles where req[0]=0.
  - Starvation of clients 1..N_REQ-1 is permitted.
- Undefined: pure round-robin across all N_REQ clients as described above.

Decomposition:
- Shared package sprite_arb_pkg:
  - typedef of tag struct {logic valid; logic [$clog2(N_REQ)-1:0] idx;}.
  - Default constants SPRITE_ADDR_W=16 and SPRITE_DATA_W=8.
- One natural sub-module, rr_picker: combinational round-robin selector taking req and ptr, producing a one-hot grant and an encoded index.
- Tag pipeline and ptr register live in the top block.

Test Plan:
- Single client: req[2]=1 with addr 0x0123 for 1 cycle → gnt=0100 that cycle; rom_addr=0x0123 and rom_rd=1 that cycle; rvalid=0100 and rdata=ROM[0x0123] exactly 2 cycles later; busy high for those 2 cycles.
- Full contention: req=1111 held for 8 cycles, ptr=0 after reset → gnt sequence 0001,0010,0100,1000,0001,0010,0100,1000; rvalid follows the same sequence delayed 2 cycles.
- Sparse fairness: ptr=2, req=1001 → gnt=1000, ptr becomes 0, next gnt=0001.
- Reset mid-flight: grant to client 1, assert Reset in the next cycle for 1 cycle → no rvalid ever appears; busy=0 and ptr=0 after reset.
- Back-to-back: client 3 issues addresses 0x10,0x11,0x12 on consecutive cycles alone → three consecutive rvalid=1000 pulses with rdata ROM[0x10], ROM[0x11], ROM[0x12] in order.
- SPRITE_ROM_ARB_PRIO0_EN defined, req=1111 held 4 cycles → gnt=0001 every cycle. Then req=1110 → gnt=0010,0100,1000.
